// File: rtl/cga_vgaport.sv
// CGA IRGB to 18-bit 6:6:6 RGB converter with a programmable 16-entry palette.
// Palette writes use a valid/ready handshake and can be deferred to blanking.
module cga_vgaport #(
    parameter int unsigned SAFE_WRITE = 1,
    parameter int unsigned BROWN_FIX  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  video,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic        pal_valid,
    output logic        pal_ready,
    input  logic [3:0]  pal_addr,
    input  logic [17:0] pal_wdata,
    input  logic        pal_default,
    output logic        pal_busy,
    output logic [17:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de
);

    localparam bit SafeWrite = (SAFE_WRITE != 0);
    localparam bit BrownFix  = (BROWN_FIX != 0);

    typedef enum logic [1:0] {StIdle, StHold, StLoad} state_e;

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  hold_addr_q;
    logic [17:0] hold_data_q;
    logic [17:0] pal_q [16];

    logic [3:0]  video_d1;
    logic        hsync_d1;
    logic        vsync_d1;
    logic        de_d1;

    logic        accept;
    logic        defer;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [17:0] wr_data;

    // Intensity lifts both levels: clear bit 00/15, set bit 2A/3F.
    function automatic logic [17:0] default_entry(input logic [3:0] i);
        logic [5:0] lo;
        logic [5:0] hi;
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        lo = i[3] ? 6'h15 : 6'h00;
        hi = i[3] ? 6'h3F : 6'h2A;
        r  = i[2] ? hi : lo;
        g  = i[1] ? hi : lo;
        b  = i[0] ? hi : lo;
        if (BrownFix && (i == 4'd6)) begin
            g = 6'h15;
        end
        return {r, g, b};
    endfunction

    assign pal_ready = (state_q == StIdle) && !pal_default;
    assign pal_busy  = (state_q != StIdle);
    assign accept    = pal_valid && pal_ready;
    assign defer     = SafeWrite && de_in;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = pal_addr;
        wr_data = pal_wdata;
        case (state_q)
            StIdle: begin
                if (accept && !defer) begin
                    wr_en = 1'b1;
                end
            end
            StHold: begin
                if (!de_in) begin
                    wr_en   = 1'b1;
                    wr_addr = hold_addr_q;
                    wr_data = hold_data_q;
                end
            end
            StLoad: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = default_entry(idx_q);
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // pal_default wins over a concurrent write; it is only looked at in idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            hold_addr_q <= 4'd0;
            hold_data_q <= 18'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pal_default) begin
                        state_q <= StLoad;
                        idx_q   <= 4'd0;
                    end else if (accept && defer) begin
                        state_q     <= StHold;
                        hold_addr_q <= pal_addr;
                        hold_data_q <= pal_wdata;
                    end
                end
                StHold: begin
                    if (!de_in) begin
                        state_q <= StIdle;
                    end
                end
                StLoad: begin
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == 4'hF) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= default_entry(4'(i));
            end
        end else if (wr_en) begin
            pal_q[wr_addr] <= wr_data;
        end
    end

    // Two-stage pixel path; the lookup sees palette writes from the previous edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_d1 <= 4'd0;
            hsync_d1 <= 1'b0;
            vsync_d1 <= 1'b0;
            de_d1    <= 1'b0;
            rgb      <= 18'd0;
            hsync    <= 1'b0;
            vsync    <= 1'b0;
            de       <= 1'b0;
        end else begin
            video_d1 <= video;
            hsync_d1 <= hsync_in;
            vsync_d1 <= vsync_in;
            de_d1    <= de_in;
            rgb      <= de_d1 ? pal_q[video_d1] : 18'd0;
            hsync    <= hsync_d1;
            vsync    <= vsync_d1;
            de       <= de_d1;
        end
    end

endmodule

// File: tb/tb_cga_vgaport.sv
// Self-checking bench for cga_vgaport: constant pixel table, directed palette
// sequences and a randomized run against a behavioural palette/pipeline model.
module tb_cga_vgaport;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  video = 4'd0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        de_in = 1'b0;
    logic        pal_valid = 1'b0;
    logic        pal_ready;
    logic [3:0]  pal_addr = 4'd0;
    logic [17:0] pal_wdata = 18'd0;
    logic        pal_default = 1'b0;
    logic        pal_busy;
    logic [17:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        de;

    cga_vgaport #(
        .SAFE_WRITE (1),
        .BROWN_FIX  (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .video       (video),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .de_in       (de_in),
        .pal_valid   (pal_valid),
        .pal_ready   (pal_ready),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
        .pal_default (pal_default),
        .pal_busy    (pal_busy),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [17:0] mpal [16];
    bit          held;
    logic [3:0]  h_addr;
    logic [17:0] h_data;
    int          load_left;
    logic [3:0]  s1_video;
    logic        s1_hs, s1_vs, s1_de;
    logic [17:0] e_rgb;
    logic        e_hs, e_vs, e_de;

    typedef struct {
        logic [3:0]  video;
        logic        de;
        logic        hs;
        logic        vs;
        logic [17:0] rgb;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Level index = 2*colour_bit + intensity, each step worth 0x15.
    function automatic logic [17:0] dflt(input int i);
        int in;
        int r;
        int g;
        int b;
        in = (i >> 3) & 1;
        r  = (2 * ((i >> 2) & 1) + in) * 21;
        g  = (2 * ((i >> 1) & 1) + in) * 21;
        b  = (2 * (i & 1) + in) * 21;
        if (i == 6) g = 21;
        return {6'(r), 6'(g), 6'(b)};
    endfunction

    function automatic bit m_ready();
        return (load_left == 0) && !held && !pal_default;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) mpal[i] = dflt(i);
        held = 0; h_addr = 4'd0; h_data = 18'd0; load_left = 0;
        s1_video = 4'd0; s1_hs = 1'b0; s1_vs = 1'b0; s1_de = 1'b0;
        e_rgb = 18'd0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
    endtask

    task automatic model_edge();
        e_rgb = s1_de ? mpal[s1_video] : 18'd0;
        e_hs  = s1_hs;
        e_vs  = s1_vs;
        e_de  = s1_de;
        if (load_left > 0) begin
            mpal[16 - load_left] = dflt(16 - load_left);
            load_left--;
        end else if (held) begin
            if (!de_in) begin
                mpal[h_addr] = h_data;
                held = 0;
            end
        end else if (pal_default) begin
            load_left = 16;
        end else if (pal_valid) begin
            if (de_in) begin
                held = 1; h_addr = pal_addr; h_data = pal_wdata;
            end else begin
                mpal[pal_addr] = pal_wdata;
            end
        end
        s1_video = video; s1_hs = hsync_in; s1_vs = vsync_in; s1_de = de_in;
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        #1;
        chk("pal_ready", 18'(pal_ready), 18'(m_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("rgb", rgb, e_rgb);
        chk("hsync", 18'(hsync), 18'(e_hs));
        chk("vsync", 18'(vsync), 18'(e_vs));
        chk("de", 18'(de), 18'(e_de));
        chk("pal_busy", 18'(pal_busy), 18'(load_left != 0 || held));
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_rgb"}, rgb, 18'd0);
        chk({tag, "_hsync"}, 18'(hsync), 18'd0);
        chk({tag, "_vsync"}, 18'(vsync), 18'd0);
        chk({tag, "_de"}, 18'(de), 18'd0);
        chk({tag, "_busy"}, 18'(pal_busy), 18'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic show(input logic [3:0] v, input string name, input logic [17:0] exp);
        video = v;
        de_in = 1'b1;
        tick();
        tick();
        chk(name, rgb, exp);
    endtask

    int cnt;
    int n;

    initial begin
        tbl[0] = '{4'h6, 1'b1, 1'b0, 1'b0, 18'h2A540};
        tbl[1] = '{4'hF, 1'b1, 1'b0, 1'b1, 18'h3FFFF};
        tbl[2] = '{4'h8, 1'b1, 1'b1, 1'b0, 18'h15555};
        tbl[3] = '{4'h1, 1'b1, 1'b0, 1'b0, 18'h0002A};
        tbl[4] = '{4'h0, 1'b1, 1'b1, 1'b1, 18'h00000};
        tbl[5] = '{4'h4, 1'b1, 1'b0, 1'b0, 18'h2A000};
        tbl[6] = '{4'h7, 1'b1, 1'b0, 1'b0, 18'h2AAAA};
        tbl[7] = '{4'h9, 1'b1, 1'b0, 1'b0, 18'h1557F};
        tbl[8] = '{4'hC, 1'b1, 1'b0, 1'b0, 18'h3F555};
        tbl[9] = '{4'hF, 1'b0, 1'b1, 1'b0, 18'h00000};

        m_reset();
        #1;
        chk("reset_rgb", rgb, 18'd0);
        chk("reset_busy", 18'(pal_busy), 18'd0);
        chk("reset_ready", 18'(pal_ready), 18'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Default palette and pipeline alignment
        for (int i = 0; i < 10; i++) begin
            video = tbl[i].video; de_in = tbl[i].de;
            hsync_in = tbl[i].hs; vsync_in = tbl[i].vs;
            tick();
            tick();
            chk("tbl_rgb", rgb, tbl[i].rgb);
            chk("tbl_hsync", 18'(hsync), 18'(tbl[i].hs));
            chk("tbl_vsync", 18'(vsync), 18'(tbl[i].vs));
            chk("tbl_de", 18'(de), 18'(tbl[i].de));
        end
        hsync_in = 1'b0; vsync_in = 1'b0;

        // Write during active video is held until blanking
        video = 4'h1; de_in = 1'b1;
        tick(); tick();
        pal_valid = 1'b1; pal_addr = 4'h1; pal_wdata = 18'h3F000;
        tick();
        pal_valid = 1'b0; pal_addr = 4'h1; pal_wdata = 18'h12345;
        #1;
        chk("hold_busy", 18'(pal_busy), 18'd1);
        chk("hold_ready", 18'(pal_ready), 18'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_rgb", rgb, 18'h0002A);
        end
        de_in = 1'b0;
        tick(); tick();
        show(4'h1, "next_line_rgb", 18'h3F000);

        // Overwrite 0..3, reload defaults, write held off until reload ends
        de_in = 1'b0;
        for (int a = 0; a < 4; a++) begin
            pal_valid = 1'b1; pal_addr = 4'(a); pal_wdata = 18'($urandom);
            tick();
        end
        pal_valid = 1'b0;
        pal_default = 1'b1;
        tick();
        pal_default = 1'b0;
        pal_valid = 1'b1; pal_addr = 4'h5; pal_wdata = 18'h01234;
        de_in = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (pal_ready) break;
            if (pal_busy) cnt++;
            video = 4'($urandom);
            tick();
        end
        chk("load_busy_cycles", 18'(cnt), 18'd16);
        tick();
        pal_valid = 1'b0;
        de_in = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) show(4'(a), "restored_rgb", dflt(a));
        show(4'h5, "post_load_write", 18'h01234);

        // Concurrent valid and default: reload first, write after
        de_in = 1'b0;
        pal_valid = 1'b1; pal_addr = 4'h2; pal_wdata = 18'h2F0F0; pal_default = 1'b1;
        #1;
        chk("both_ready", 18'(pal_ready), 18'd0);
        tick();
        pal_default = 1'b0;
        n = 0;
        while (!pal_ready && n < 40) begin
            tick();
            n++;
        end
        chk("both_wait", 18'(n), 18'd16);
        tick();
        pal_valid = 1'b0;
        show(4'h2, "both_write", 18'h2F0F0);

        // Reset while a write is held
        hsync_in = 1'b1; vsync_in = 1'b1; video = 4'h2; de_in = 1'b1;
        tick(); tick();
        pal_valid = 1'b1; pal_addr = 4'h3; pal_wdata = 18'h11111;
        tick();
        pal_valid = 1'b0;
        tick();
        do_reset("rst_hold");
        hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
        tick();
        show(4'h3, "rst_hold_lost", dflt(3));
        show(4'h2, "rst_hold_pal", dflt(2));

        // Reset mid-reload
        de_in = 1'b0;
        pal_valid = 1'b1; pal_addr = 4'hA; pal_wdata = 18'h00F0F;
        tick();
        pal_valid = 1'b0;
        pal_default = 1'b1;
        tick();
        pal_default = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        do_reset("rst_load");
        tick();
        show(4'hA, "rst_load_pal", dflt(10));

        // Randomized run against the model
        de_in = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            video    = 4'($urandom);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            if ($urandom_range(0, 15) == 0) de_in = ~de_in;
            pal_valid   = ($urandom_range(0, 3) == 0);
            pal_addr    = 4'($urandom);
            pal_wdata   = 18'($urandom);
            pal_default = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
